sobel_stream: RTL and testbench

- Streaming, parametrised successor to the whole-frame sobel_filter.
- Accepts a raster-scan pixel stream, one pixel per cycle, under a valid/ready handshake. Buffers two image lines internally and emits the 3x3 Sobel result for every interior pixel.
- Replaces the full-frame combinational array, so frames of realistic size fit on the FPGA.
- Adds selectable output mode and binary thresholding.

---
 rtl/sobel_stream.sv | 101 ++++++++++
 tb/tb_sobel_stream.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/sobel_stream.sv
// sobel_stream: line-buffered 3x3 Sobel edge filter over a valid/ready raster pixel stream
module sobel_stream #(
  parameter int WIDTH_P   = 64,
  parameter int HEIGHT_P  = 64,
  parameter int PIXEL_W_P = 8
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 valid_i,
  input  logic [PIXEL_W_P-1:0] pixel_i,
  output logic                 ready_o,
  input  logic [1:0]           mode_i,
  input  logic [PIXEL_W_P-1:0] thresh_i,
  output logic                 valid_o,
  output logic [PIXEL_W_P-1:0] pixel_o,
  output logic                 last_o,
  input  logic                 ready_i
);
  localparam int CW = $clog2(WIDTH_P);
  localparam int RW = $clog2(HEIGHT_P);
  localparam int S  = PIXEL_W_P + 3;
  logic [CW-1:0]        col;
  logic [RW-1:0]        row;
  logic [PIXEL_W_P-1:0] lb0 [WIDTH_P];
  logic [PIXEL_W_P-1:0] lb1 [WIDTH_P];
  logic [PIXEL_W_P-1:0] w   [3][3];
  logic [PIXEL_W_P-1:0] nw  [3][3];
  logic [1:0]           mode;
  logic [PIXEL_W_P-1:0] thresh;
  logic                 fire, prod, eol, eof;
  logic [S-1:0]         gx, gy, ax, ay, sum;
  logic [PIXEL_W_P-1:0] res;
  function automatic logic [S-1:0] x(input logic [PIXEL_W_P-1:0] p);
    return S'(p);
  endfunction
  function automatic logic [PIXEL_W_P-1:0] sat(input logic [S-1:0] v);
    return (v[S-1:PIXEL_W_P] != '0) ? '1 : v[PIXEL_W_P-1:0];
  endfunction
  assign ready_o = ~valid_o | ready_i;
  assign fire    = valid_i & ready_o;
  assign eol     = col == CW'(WIDTH_P - 1);
  assign eof     = row == RW'(HEIGHT_P - 1);
  assign prod    = fire & (row >= RW'(2)) & (col >= CW'(2));
  // The result is computed from the window as it will look after this fire,
  // so the output register holds it one cycle after the triggering pixel.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      nw[i][0] = w[i][1];
      nw[i][1] = w[i][2];
    end
    nw[0][2] = lb1[col];
    nw[1][2] = lb0[col];
    nw[2][2] = pixel_i;
  end
  assign gx  = x(nw[0][2]) + (x(nw[1][2]) << 1) + x(nw[2][2])
             - x(nw[0][0]) - (x(nw[1][0]) << 1) - x(nw[2][0]);
  assign gy  = x(nw[2][0]) + (x(nw[2][1]) << 1) + x(nw[2][2])
             - x(nw[0][0]) - (x(nw[0][1]) << 1) - x(nw[0][2]);
  assign ax  = gx[S-1] ? -gx : gx;
  assign ay  = gy[S-1] ? -gy : gy;
  assign sum = ax + ay;
  assign res = mode == 2'd0 ? sat(sum) :
               mode == 2'd1 ? sat(ax) :
               mode == 2'd2 ? sat(ay) :
               {PIXEL_W_P{sat(sum) >= thresh}};
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      col     <= '0;
      row     <= '0;
      mode    <= '0;
      thresh  <= '0;
      valid_o <= 1'b0;
      pixel_o <= '0;
      last_o  <= 1'b0;
    end else begin
      if (fire) begin
        col <= eol ? '0 : col + 1'b1;
        if (eol) row <= eof ? '0 : row + 1'b1;
        if (row == '0 && col == '0) begin
          mode   <= mode_i;
          thresh <= thresh_i;
        end
      end
      if (prod) begin
        valid_o <= 1'b1;
        pixel_o <= res;
        last_o  <= eol & eof;
      end else if (ready_i) begin
        valid_o <= 1'b0;
        last_o  <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk_i) begin
    if (fire) begin
      lb0[col] <= pixel_i;
      lb1[col] <= lb0[col];
      w        <= nw;
    end
  end
endmodule

// File: tb/tb_sobel_stream.sv
// tb_sobel_stream: directed table-driven bench for sobel_stream on an 8x6 frame
module tb_sobel_stream;
  localparam int W = 8;
  localparam int H = 6;
  localparam int N = W * H;
  logic       clk = 0;
  logic       reset_i, valid_i, ready_i, ready_o, valid_o, last_o;
  logic [7:0] pixel_i, thresh_i, pixel_o;
  logic [1:0] mode_i;
  int         total = 0, bad = 0;
  logic [7:0] got_pix[$];
  bit         got_last[$];
  bit         stall_prev = 0, stall_last;
  logic [7:0] stall_pix;
  typedef struct {
    int             kind;
    logic [1:0]     mode;
    logic [7:0]     th;
    bit             gap;
    bit             rnd;
    logic [0:5][7:0] exp;
  } vec_t;
  vec_t tbl[11];

  sobel_stream #(.WIDTH_P(W), .HEIGHT_P(H), .PIXEL_W_P(8)) dut (
    .clk_i(clk), .reset_i(reset_i), .valid_i(valid_i), .pixel_i(pixel_i),
    .ready_o(ready_o), .mode_i(mode_i), .thresh_i(thresh_i), .valid_o(valid_o),
    .pixel_o(pixel_o), .last_o(last_o), .ready_i(ready_i)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // kinds: 0 flat 0x80, 1 vertical step, 2 column ramp, 3 row ramp
  function automatic logic [7:0] pix(input int k, input int r, input int c);
    return k == 0 ? 8'h80 : k == 1 ? (c >= 4 ? 8'hFF : 8'h00) : k == 2 ? 8'(c * 16) : 8'(r * 16);
  endfunction

  always @(negedge clk) begin
    if (reset_i) stall_prev = 0;
    else begin
      if (stall_prev) chk("stall_hold", {22'd0, valid_o, last_o, pixel_o}, {22'd0, 1'b1, stall_last, stall_pix});
      if (valid_o && ready_i) begin
        got_pix.push_back(pixel_o);
        got_last.push_back(last_o);
      end
      stall_prev = valid_o && !ready_i;
      stall_pix  = pixel_o;
      stall_last = last_o;
    end
  end

  task automatic send(input logic [7:0] p, input bit gap, input bit rnd);
    int  n = 0;
    bit  done = 0;
    if (gap && $urandom_range(0, 2) == 0) begin
      valid_i = 0;
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
    end
    valid_i = 1;
    pixel_i = p;
    while (!done) begin
      ready_i = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (ready_o) done = 1;
      @(posedge clk); #1;
      if (!done && ++n > 1000) begin
        chk("accept_timeout", 1, 0);
        done = 1;
      end
    end
    valid_i = 0;
  endtask

  task automatic run_frame(input int kind, input bit gap, input bit rnd, input bit lat, input int k0, input int k1);
    for (int k = k0; k < k1; k++) begin
      send(pix(kind, k / W, k % W), gap, rnd);
      if (lat) begin
        chk("lat_valid", {31'd0, valid_o}, {31'd0, 1'((k / W) >= 2 && (k % W) >= 2)});
        chk("lat_last", {31'd0, last_o}, {31'd0, 1'(k == N - 1)});
      end
    end
  endtask

  task automatic drain();
    valid_i = 0;
    ready_i = 1;
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic check_out(input logic [0:5][7:0] exp, input int base, input string tag);
    for (int i = 0; i < 24; i++) begin
      int         idx = base + i;
      logic [8:0] act = 'x;
      if (idx < got_pix.size()) act = {got_last[idx], got_pix[idx]};
      chk(tag, {23'd0, act}, {23'd0, 1'(i == 23), exp[i % 6]});
    end
  endtask

  task automatic clear_q();
    got_pix.delete();
    got_last.delete();
  endtask

  initial begin
    tbl[0]  = '{0, 2'd0, 8'h00, 0, 0, 48'h000000000000};
    tbl[1]  = '{1, 2'd0, 8'h00, 0, 0, 48'h0000FFFF0000};
    tbl[2]  = '{1, 2'd2, 8'h00, 0, 0, 48'h000000000000};
    tbl[3]  = '{1, 2'd3, 8'h80, 0, 0, 48'h0000FFFF0000};
    tbl[4]  = '{1, 2'd0, 8'h00, 1, 1, 48'h0000FFFF0000};
    tbl[5]  = '{2, 2'd0, 8'h00, 0, 0, 48'h808080808080};
    tbl[6]  = '{2, 2'd3, 8'h80, 0, 0, 48'hFFFFFFFFFFFF};
    tbl[7]  = '{2, 2'd3, 8'h81, 1, 1, 48'h000000000000};
    tbl[8]  = '{3, 2'd2, 8'h00, 0, 0, 48'h808080808080};
    tbl[9]  = '{3, 2'd1, 8'h00, 0, 0, 48'h000000000000};
    tbl[10] = '{2, 2'd1, 8'h00, 1, 1, 48'h808080808080};
    reset_i = 1; valid_i = 0; ready_i = 1; pixel_i = 0; mode_i = 0; thresh_i = 0;
    repeat (3) @(posedge clk);
    #1 reset_i = 0;
    chk("rst_valid", {31'd0, valid_o}, 0);
    chk("rst_pixel", {24'd0, pixel_o}, 0);
    chk("rst_last", {31'd0, last_o}, 0);
    chk("rst_ready", {31'd0, ready_o}, 1);
    for (int i = 0; i < 11; i++) begin
      clear_q();
      mode_i   = tbl[i].mode;
      thresh_i = tbl[i].th;
      run_frame(tbl[i].kind, tbl[i].gap, tbl[i].rnd, i == 0, 0, N);
      drain();
      chk("count", got_pix.size(), 24);
      check_out(tbl[i].exp, 0, "frame_out");
    end
    // back-to-back frames: mode change mid-frame 1 applies only to frame 2
    clear_q();
    mode_i = 0;
    run_frame(3, 0, 0, 0, 0, 20);
    mode_i = 1;
    run_frame(3, 0, 0, 0, 20, N);
    run_frame(3, 0, 0, 0, 0, N);
    drain();
    chk("b2b_count", got_pix.size(), 48);
    check_out(48'h808080808080, 0, "b2b_f1");
    check_out(48'h000000000000, 24, "b2b_f2");
    // reset after 20 fires discards the partial frame
    mode_i = 0;
    run_frame(1, 0, 0, 0, 0, 20);
    reset_i = 1;
    @(posedge clk); #1;
    chk("midrst_valid", {31'd0, valid_o}, 0);
    chk("midrst_last", {31'd0, last_o}, 0);
    reset_i = 0;
    clear_q();
    run_frame(1, 0, 0, 0, 0, N);
    drain();
    chk("midrst_count", got_pix.size(), 24);
    check_out(48'h0000FFFF0000, 0, "midrst_out");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
